// File: rtl/spi_reg_bridge.sv
// SPI register bridge: decodes SPI-slave RX bytes into register reads/writes and returns read data on the TX byte port.
// Define SPI_REG_BRIDGE_AUTOINC_EN for burst accesses with address auto-increment within a frame.
module spi_reg_bridge #(
   parameter int         ADDR_WIDTH   = 7,
   parameter logic [7:0] IDLE_TX_BYTE = 8'h00
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_SPI_CS_n,
   output logic                  o_TX_DV,
   output logic [7:0]            o_TX_Byte,
   output logic                  o_Reg_Wr,
   output logic                  o_Reg_Rd,
   output logic [ADDR_WIDTH-1:0] o_Reg_Addr,
   output logic [7:0]            o_Reg_WData,
   input  logic [7:0]            i_Reg_RData,
   output logic                  o_Busy
);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, WR_WAIT, WR_DONE, RD_REQ, RD_CAP, RD_WAIT
   } state_t;

   state_t                r_State, w_Next_State;
   logic                  r_CS_Meta, r_CS_Sync, r_CS_Prev;
   logic                  w_Frame_End, w_RX;
   logic                  w_TX_DV, w_Reg_Wr;
   logic [7:0]            w_TX_Byte, w_Reg_WData;
   logic [ADDR_WIDTH-1:0] w_Reg_Addr;

   // Synchroniser flops reset to "deselected" so reset never looks like a frame edge.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_CS_Meta <= 1'b1;
         r_CS_Sync <= 1'b1;
         r_CS_Prev <= 1'b1;
      end else begin
         r_CS_Meta <= i_SPI_CS_n;
         r_CS_Sync <= r_CS_Meta;
         r_CS_Prev <= r_CS_Sync;
      end
   end

   assign w_Frame_End = r_CS_Sync & ~r_CS_Prev;
   // Bytes arriving while deselected (including the frame-end cycle) are dropped.
   assign w_RX        = i_RX_DV & ~r_CS_Sync;
   assign o_Busy      = ~r_CS_Sync;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) r_State <= IDLE;
      else       r_State <= w_Next_State;
   end

   always_comb begin
      w_Next_State = r_State;
      w_Reg_Addr   = o_Reg_Addr;
      w_Reg_Wr     = 1'b0;
      w_Reg_WData  = o_Reg_WData;
      w_TX_DV      = 1'b0;
      w_TX_Byte    = o_TX_Byte;
      o_Reg_Rd     = 1'b0;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      // Step past the address just written, ready for the next burst byte.
      if (o_Reg_Wr) w_Reg_Addr = o_Reg_Addr + ADDR_ONE;
`endif
      if (w_Frame_End) begin
         w_Next_State = IDLE;
         w_TX_DV      = 1'b1;
         w_TX_Byte    = IDLE_TX_BYTE;
      end else begin
         case (r_State)
            IDLE: begin
               if (w_RX) begin
                  w_Reg_Addr   = i_RX_Byte[ADDR_WIDTH-1:0];
                  w_Next_State = i_RX_Byte[7] ? RD_REQ : WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (w_RX) begin
                  w_Reg_Wr    = 1'b1;
                  w_Reg_WData = i_RX_Byte;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
                  w_Next_State = WR_WAIT;
`else
                  w_Next_State = WR_DONE;
`endif
               end
            end
            RD_REQ: begin
               o_Reg_Rd     = 1'b1;
               w_Next_State = RD_CAP;
            end
            RD_CAP: begin
               w_TX_DV      = 1'b1;
               w_TX_Byte    = i_Reg_RData;
               w_Next_State = RD_WAIT;
            end
            RD_WAIT: begin
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
               // The dummy byte shifting out this data fetches the next address.
               if (w_RX) begin
                  w_Reg_Addr   = o_Reg_Addr + ADDR_ONE;
                  w_Next_State = RD_REQ;
               end
`endif
            end
            WR_DONE: ;
            default: w_Next_State = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Reg_Addr  <= '0;
         o_Reg_Wr    <= 1'b0;
         o_Reg_WData <= '0;
         o_TX_DV     <= 1'b0;
         o_TX_Byte   <= IDLE_TX_BYTE;
      end else begin
         o_Reg_Addr  <= w_Reg_Addr;
         o_Reg_Wr    <= w_Reg_Wr;
         o_Reg_WData <= w_Reg_WData;
         o_TX_DV     <= w_TX_DV;
         o_TX_Byte   <= w_TX_Byte;
      end
   end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed protocol cases plus random frames checked against a frame-level model.
module tb_spi_reg_bridge;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } ev_t;

   logic       i_Clk = 1'b0, i_Rst = 1'b1, i_RX_DV = 1'b0, i_SPI_CS_n = 1'b1;
   logic [7:0] i_RX_Byte = 8'h00;
   logic [7:0] i_Reg_RData;
   logic       o_TX_DV, o_Reg_Wr, o_Reg_Rd, o_Busy;
   logic [7:0] o_TX_Byte, o_Reg_WData;
   logic [6:0] o_Reg_Addr;

   spi_reg_bridge dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
      .i_SPI_CS_n(i_SPI_CS_n), .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
      .o_Reg_Wr(o_Reg_Wr), .o_Reg_Rd(o_Reg_Rd), .o_Reg_Addr(o_Reg_Addr),
      .o_Reg_WData(o_Reg_WData), .i_Reg_RData(i_Reg_RData), .o_Busy(o_Busy)
   );

   always #5 i_Clk = ~i_Clk;

   int         checks = 0, errors = 0, cyc = 0, excl = 0;
   logic [7:0] mem [128];
   ev_t        wr_q[$], rd_q[$], tx_q[$], exp_wr[$], exp_rd[$], exp_tx[$];
   int         rx_cyc[$];
   int         wb, rb, tbs;
   logic [7:0] fb [8];
   bit         rd_seen = 1'b0;
   logic [6:0] rd_addr = 7'h00;

   always @(posedge i_Clk) cyc <= cyc + 1;

   // Bus monitor and register-file responder: read data is valid only in the cycle after o_Reg_Rd.
   always @(negedge i_Clk) begin
      i_Reg_RData = rd_seen ? mem[rd_addr] : 8'($urandom);
      rd_seen     = 1'b0;
      if (!i_Rst) begin
         if (o_Reg_Rd && o_Reg_Wr) excl = excl + 1;
         if (o_Reg_Rd) begin
            rd_q.push_back('{cyc, {1'b0, o_Reg_Addr}, 8'h00});
            rd_seen = 1'b1;
            rd_addr = o_Reg_Addr;
         end
         if (o_Reg_Wr) wr_q.push_back('{cyc, {1'b0, o_Reg_Addr}, o_Reg_WData});
         if (o_TX_DV)  tx_q.push_back('{cyc, 8'h00, o_TX_Byte});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_dv"}, o_TX_DV, 0);
      chk({tag, "_tx_byte"}, o_TX_Byte, 8'h00);
      chk({tag, "_wr"}, o_Reg_Wr, 0);
      chk({tag, "_rd"}, o_Reg_Rd, 0);
      chk({tag, "_addr"}, o_Reg_Addr, 0);
      chk({tag, "_wdata"}, o_Reg_WData, 0);
      chk({tag, "_busy"}, o_Busy, 0);
   endtask

   task automatic mark();
      wb = wr_q.size(); rb = rd_q.size(); tbs = tx_q.size();
      rx_cyc.delete();
   endtask

   task automatic cs_low();
      @(negedge i_Clk); i_SPI_CS_n = 1'b0;
      repeat (4) @(negedge i_Clk);
      chk("busy_hi", o_Busy, 1);
   endtask

   task automatic cs_high();
      @(negedge i_Clk); i_SPI_CS_n = 1'b1;
      repeat (6) @(negedge i_Clk);
      chk("busy_lo", o_Busy, 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_Clk); i_RX_DV = 1'b1; i_RX_Byte = b; rx_cyc.push_back(cyc);
      @(negedge i_Clk); i_RX_DV = 1'b0;
      repeat (6) @(negedge i_Clk);
   endtask

   // Frame-level expectation: what a register bus should see for the byte sequence fb[0..n-1].
   task automatic model(input int n);
      logic [6:0] a, ak;
      a = fb[0][6:0];
      exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
      if (fb[0][7]) begin
         for (int k = 0; k < n; k++) if (k == 0 || AUTOINC) begin
            ak = a + 7'(k);
            exp_rd.push_back('{0, {1'b0, ak}, 8'h00});
            exp_tx.push_back('{0, 8'h00, mem[ak]});
         end
      end else begin
         for (int k = 1; k < n; k++) if (k == 1 || AUTOINC) begin
            ak = a + 7'(k - 1);
            exp_wr.push_back('{0, {1'b0, ak}, fb[k]});
         end
      end
      exp_tx.push_back('{0, 8'h00, 8'h00});
   endtask

   task automatic cmp_q(input string tag, input ev_t got[$], input int base, input ev_t exp[$],
                        input bit use_a, input bit use_d);
      chk({tag, "_count"}, got.size() - base, exp.size());
      for (int i = 0; i < exp.size(); i++) if (base + i < got.size()) begin
         if (use_a) chk({tag, "_addr"}, got[base+i].a, exp[i].a);
         if (use_d) chk({tag, "_data"}, got[base+i].d, exp[i].d);
      end
   endtask

   task automatic run_frame(input string tag, input int n);
      model(n);
      mark();
      cs_low();
      for (int k = 0; k < n; k++) send_byte(fb[k]);
      cs_high();
      cmp_q({tag, "_wr"}, wr_q, wb, exp_wr, 1'b1, 1'b1);
      cmp_q({tag, "_rd"}, rd_q, rb, exp_rd, 1'b1, 1'b0);
      cmp_q({tag, "_tx"}, tx_q, tbs, exp_tx, 1'b0, 1'b1);
      for (int i = wb; i < wr_q.size(); i++) mem[wr_q[i].a[6:0]] = wr_q[i].d;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge i_Clk);
      chk_reset("reset");
      i_Rst = 1'b0;
      repeat (3) @(negedge i_Clk);

      // Single write with strobe latency.
      fb[0] = 8'h05; fb[1] = 8'hA7;
      run_frame("write", 2);
      if (wr_q.size() > wb) chk("write_lat", wr_q[wb].cyc - rx_cyc[1], 1);

      // Single read: strobe one cycle and TX three cycles after the command.
      mem[3] = 8'h3C; fb[0] = 8'h83;
      run_frame("read", 1);
      if (rd_q.size() > rb)   chk("read_rd_lat", rd_q[rb].cyc - rx_cyc[0], 1);
      if (tx_q.size() > tbs)  chk("read_tx_lat", tx_q[tbs].cyc - rx_cyc[0], 3);

      // Burst write across the address wrap.
      fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22;
      run_frame("burst_wr", 3);

      // Abort: synced CS rises the cycle after a read command.
      mark();
      cs_low();
      @(negedge i_Clk); i_SPI_CS_n = 1'b1;
      @(negedge i_Clk); i_RX_DV = 1'b1; i_RX_Byte = 8'h83;
      @(negedge i_Clk); i_RX_DV = 1'b0;
      repeat (6) @(negedge i_Clk);
      chk("abort_rd_count", rd_q.size() - rb, 0);
      chk("abort_tx_count", tx_q.size() - tbs, 1);
      if (tx_q.size() > tbs) chk("abort_tx_byte", tx_q[tbs].d, 8'h00);
      chk("abort_busy", o_Busy, 0);
      fb[0] = 8'h90; fb[1] = 8'h00;
      run_frame("after_abort", 2);

      // Collision: data byte lands exactly on the synced CS rising edge.
      mark();
      cs_low();
      send_byte(8'h05);
      @(negedge i_Clk); i_SPI_CS_n = 1'b1;
      @(negedge i_Clk);
      @(negedge i_Clk); i_RX_DV = 1'b1; i_RX_Byte = 8'hA5;
      @(negedge i_Clk); i_RX_DV = 1'b0;
      repeat (5) @(negedge i_Clk);
      chk("collide_wr_count", wr_q.size() - wb, 0);
      chk("collide_rd_count", rd_q.size() - rb, 0);
      chk("collide_tx_count", tx_q.size() - tbs, 1);

      // Asynchronous reset while the read strobe is up.
      cs_low();
      @(negedge i_Clk); i_RX_DV = 1'b1; i_RX_Byte = 8'h85;
      @(negedge i_Clk); i_RX_DV = 1'b0;
      chk("midrst_rd_before", o_Reg_Rd, 1);
      i_Rst = 1'b1;
      #1;
      chk_reset("midrst");
      repeat (2) @(negedge i_Clk);
      i_Rst = 1'b0;
      repeat (3) @(negedge i_Clk);
      i_SPI_CS_n = 1'b1;
      repeat (6) @(negedge i_Clk);
      fb[0] = 8'h12; fb[1] = 8'h5A;
      run_frame("post_rst", 2);

      // Random frames.
      for (int f = 0; f < 25; f++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) fb[k] = 8'($urandom);
         run_frame("rand", n);
      end

      chk("rd_wr_excl", excl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
